// File: rtl/control_sequencer_team1_pkg.sv
// Shared encodings for the basic-computer control sequencer.
package control_pkg_team1;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned SC_W   = 3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6,
        ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        BUS_NONE = 3'b000,
        BUS_AR   = 3'b001,
        BUS_PC   = 3'b010,
        BUS_DR   = 3'b011,
        BUS_AC   = 3'b100,
        BUS_IR   = 3'b101,
        BUS_TR   = 3'b110,
        BUS_MEM  = 3'b111
    } bus_sel_t;

    typedef enum logic [2:0] {
        ALU_NONE = 3'b000,
        ALU_AND  = 3'b001,
        ALU_ADD  = 3'b010,
        ALU_LDDR = 3'b011,
        ALU_CMA  = 3'b100
    } alu_op_t;

    localparam logic [2:0] OP_AND    = 3'd0;
    localparam logic [2:0] OP_ADD    = 3'd1;
    localparam logic [2:0] OP_LDA    = 3'd2;
    localparam logic [2:0] OP_STA    = 3'd3;
    localparam logic [2:0] OP_BUN    = 3'd4;
    localparam logic [2:0] OP_BSA    = 3'd5;
    localparam logic [2:0] OP_ISZ    = 3'd6;
    localparam logic [2:0] OP_REGREF = 3'd7;

    localparam int unsigned RR_CLA = 11;
    localparam int unsigned RR_CMA = 9;
    localparam int unsigned RR_INC = 5;
    localparam int unsigned RR_SNA = 3;
    localparam int unsigned RR_SZA = 2;
    localparam int unsigned RR_HLT = 0;

    // One cycle's worth of datapath control.
    typedef struct packed {
        bus_sel_t bus_sel;
        logic     ld_ar;
        logic     ld_pc;
        logic     ld_dr;
        logic     ld_ac;
        logic     ld_ir;
        logic     inc_ar;
        logic     inc_pc;
        logic     inc_dr;
        logic     inc_ac;
        logic     clr_ac;
        logic     mem_write;
        alu_op_t  alu_op;
    } ctrl_t;

endpackage

// File: rtl/control_sequencer_team1_if.sv
// Sequencer <-> datapath control/status bundle.
interface control_sequencer_team1_if
    import control_pkg_team1::*;
();
    logic              run;
    logic [DATA_W-1:0] ir;
    logic              ac_zero;
    logic              ac_msb;
    logic              dr_zero;
    logic [2:0]        bus_sel;
    logic              ld_ar, ld_pc, ld_dr, ld_ac, ld_ir;
    logic              inc_ar, inc_pc, inc_dr, inc_ac, clr_ac;
    logic              mem_write;
    logic [2:0]        alu_op;
    logic [SC_W-1:0]   sc;
    logic              halted;

    modport master (
        input  run, ir, ac_zero, ac_msb, dr_zero,
        output bus_sel, ld_ar, ld_pc, ld_dr, ld_ac, ld_ir,
        output inc_ar, inc_pc, inc_dr, inc_ac, clr_ac,
        output mem_write, alu_op, sc, halted
    );

    modport slave (
        output run, ir, ac_zero, ac_msb, dr_zero,
        input  bus_sel, ld_ar, ld_pc, ld_dr, ld_ac, ld_ir,
        input  inc_ar, inc_pc, inc_dr, inc_ac, clr_ac,
        input  mem_write, alu_op, sc, halted
    );
endinterface

// File: rtl/control_sequencer_team1_reg_ref_decoder.sv
// Register-reference instruction decode (all requested micro-ops act together).
module reg_ref_decoder_team1
    import control_pkg_team1::*;
(
    input  logic [ADDR_W-1:0] rr_bits,
    input  logic              ac_zero,
    input  logic              ac_msb,
    output logic              clr_ac,
    output logic              ld_ac,
    output alu_op_t           alu_op,
    output logic              inc_ac,
    output logic              inc_pc,
    output logic              hlt_req
);
    // Bits with no action in this instruction subset.
    logic unused_rr_bits;
    assign unused_rr_bits = ^{rr_bits[10], rr_bits[8:6], rr_bits[4], rr_bits[1]};

    // CLA wins over CMA so AC never sees a load and a clear together.
    always_comb begin
        clr_ac  = rr_bits[RR_CLA];
        ld_ac   = rr_bits[RR_CMA] & ~rr_bits[RR_CLA];
        alu_op  = ld_ac ? ALU_CMA : ALU_NONE;
        inc_ac  = rr_bits[RR_INC];
        inc_pc  = (rr_bits[RR_SNA] & ac_msb) | (rr_bits[RR_SZA] & ac_zero);
        hlt_req = rr_bits[RR_HLT];
    end
endmodule

// File: rtl/control_sequencer_team1.sv
// Sequence-counter control unit: fetch, decode, indirect and execute timing.
module control_sequencer_team1
    import control_pkg_team1::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    control_sequencer_team1_if.master   bus
);
    state_t          state_q, state_d;
    logic            i_bit_q;
    logic [2:0]      opcode_q;
    ctrl_t           ctrl;
    logic [SC_W-1:0] sc;
    logic            halted;
    logic            end_instr;

    logic    rr_clr_ac, rr_ld_ac, rr_inc_ac, rr_inc_pc, rr_hlt_req;
    alu_op_t rr_alu_op;

    reg_ref_decoder_team1 u_rr_dec (
        .rr_bits (bus.ir[ADDR_W-1:0]),
        .ac_zero (bus.ac_zero),
        .ac_msb  (bus.ac_msb),
        .clr_ac  (rr_clr_ac),
        .ld_ac   (rr_ld_ac),
        .alu_op  (rr_alu_op),
        .inc_ac  (rr_inc_ac),
        .inc_pc  (rr_inc_pc),
        .hlt_req (rr_hlt_req)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Latch I and opcode as IR is decoded at the end of T2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_bit_q  <= 1'b0;
            opcode_q <= 3'b000;
        end else if (state_q == ST_T2) begin
            i_bit_q  <= bus.ir[DATA_W-1];
            opcode_q <= bus.ir[DATA_W-2:ADDR_W];
        end
    end

    // Next-state and per-cycle strobe decode.
    always_comb begin
        ctrl      = '0;
        state_d   = state_q;
        end_instr = 1'b0;
        sc        = '0;
        halted    = 1'b0;
        case (state_q)
            ST_IDLE: if (bus.run) state_d = ST_T0;
            ST_T0: begin
                sc           = SC_W'(0);
                ctrl.bus_sel = BUS_PC;
                ctrl.ld_ar   = 1'b1;
                state_d      = ST_T1;
            end
            ST_T1: begin
                sc           = SC_W'(1);
                ctrl.bus_sel = BUS_MEM;
                ctrl.ld_ir   = 1'b1;
                ctrl.inc_pc  = 1'b1;
                state_d      = ST_T2;
            end
            ST_T2: begin
                sc           = SC_W'(2);
                ctrl.bus_sel = BUS_IR;
                ctrl.ld_ar   = 1'b1;
                state_d      = ST_T3;
            end
            ST_T3: begin
                sc = SC_W'(3);
                if (opcode_q == OP_REGREF) begin
                    if (!i_bit_q) begin
                        ctrl.clr_ac = rr_clr_ac;
                        ctrl.ld_ac  = rr_ld_ac;
                        ctrl.alu_op = rr_alu_op;
                        ctrl.inc_ac = rr_inc_ac;
                        ctrl.inc_pc = rr_inc_pc;
                    end
                    if (!i_bit_q && rr_hlt_req) state_d   = ST_HALT;
                    else                        end_instr = 1'b1;
                end else begin
                    if (i_bit_q) begin
                        ctrl.bus_sel = BUS_MEM;
                        ctrl.ld_ar   = 1'b1;
                    end
                    state_d = ST_T4;
                end
            end
            ST_T4: begin
                sc = SC_W'(4);
                case (opcode_q)
                    OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
                        ctrl.bus_sel = BUS_MEM;
                        ctrl.ld_dr   = 1'b1;
                        state_d      = ST_T5;
                    end
                    OP_STA: begin
                        ctrl.bus_sel   = BUS_AC;
                        ctrl.mem_write = 1'b1;
                        end_instr      = 1'b1;
                    end
                    OP_BUN: begin
                        ctrl.bus_sel = BUS_AR;
                        ctrl.ld_pc   = 1'b1;
                        end_instr    = 1'b1;
                    end
                    OP_BSA: begin
                        ctrl.bus_sel   = BUS_PC;
                        ctrl.mem_write = 1'b1;
                        ctrl.inc_ar    = 1'b1;
                        state_d        = ST_T5;
                    end
                    default: end_instr = 1'b1;
                endcase
            end
            ST_T5: begin
                sc = SC_W'(5);
                case (opcode_q)
                    OP_AND: begin ctrl.alu_op = ALU_AND;  ctrl.ld_ac = 1'b1; end_instr = 1'b1; end
                    OP_ADD: begin ctrl.alu_op = ALU_ADD;  ctrl.ld_ac = 1'b1; end_instr = 1'b1; end
                    OP_LDA: begin ctrl.alu_op = ALU_LDDR; ctrl.ld_ac = 1'b1; end_instr = 1'b1; end
                    OP_BSA: begin
                        ctrl.bus_sel = BUS_AR;
                        ctrl.ld_pc   = 1'b1;
                        end_instr    = 1'b1;
                    end
                    OP_ISZ: begin
                        ctrl.inc_dr = 1'b1;
                        state_d     = ST_T6;
                    end
                    default: end_instr = 1'b1;
                endcase
            end
            ST_T6: begin
                sc             = SC_W'(6);
                ctrl.bus_sel   = BUS_DR;
                ctrl.mem_write = 1'b1;
                ctrl.inc_pc    = bus.dr_zero;
                end_instr      = 1'b1;
            end
            ST_HALT: halted = 1'b1;
            default: state_d = ST_IDLE;
        endcase
        // run is only consulted here, so a low run never aborts an instruction.
        if (end_instr) state_d = bus.run ? ST_T0 : ST_IDLE;
    end

    assign bus.bus_sel   = ctrl.bus_sel;
    assign bus.ld_ar     = ctrl.ld_ar;
    assign bus.ld_pc     = ctrl.ld_pc;
    assign bus.ld_dr     = ctrl.ld_dr;
    assign bus.ld_ac     = ctrl.ld_ac;
    assign bus.ld_ir     = ctrl.ld_ir;
    assign bus.inc_ar    = ctrl.inc_ar;
    assign bus.inc_pc    = ctrl.inc_pc;
    assign bus.inc_dr    = ctrl.inc_dr;
    assign bus.inc_ac    = ctrl.inc_ac;
    assign bus.clr_ac    = ctrl.clr_ac;
    assign bus.mem_write = ctrl.mem_write;
    assign bus.alu_op    = ctrl.alu_op;
    assign bus.sc        = sc;
    assign bus.halted    = halted;
endmodule

// File: tb/tb_control_sequencer_team1.sv
// Directed bench for the control sequencer; outputs checked at mid-cycle.
module tb_control_sequencer_team1;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    control_sequencer_team1_if bus ();

    control_sequencer_team1 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Output snapshot: {bus_sel, ld ar/pc/dr/ac/ir, inc ar/pc/dr/ac + clr_ac, mem_write, alu_op, sc, halted}
    function automatic logic [20:0] snap();
        return {bus.bus_sel, bus.ld_ar, bus.ld_pc, bus.ld_dr, bus.ld_ac, bus.ld_ir,
                bus.inc_ar, bus.inc_pc, bus.inc_dr, bus.inc_ac, bus.clr_ac,
                bus.mem_write, bus.alu_op, bus.sc, bus.halted};
    endfunction

    function automatic logic [20:0] mk(input logic [2:0] bs, input logic [4:0] ld,
                                       input logic [4:0] ic, input logic mw,
                                       input logic [2:0] alu, input logic [2:0] scv,
                                       input logic h);
        return {bs, ld, ic, mw, alu, scv, h};
    endfunction

    // Reset, load new IR, and step into T0 with run high.
    task automatic go_t0(input logic [15:0] ir_v);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n  = 1'b1;
        bus.ir  = ir_v;
        bus.run = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [20:0] got;
        @(negedge clk);
        #1;
        n_tests++;
        got = snap();
        if (got !== 21'h0) begin
            n_fail++;
            $display("FAIL reset_hold got %h want %h", got, 21'h0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            n_tests++;
            got = snap();
            if (got !== 21'h0) begin
                n_fail++;
                $display("FAIL idle_cyc%0d got %h want %h", i, got, 21'h0);
            end
        end
        bus.ir  = 16'h1005;
        bus.run = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        n_tests++;
        got = snap();
        if (got !== mk(3'd7, 5'b00100, 5'b0, 1'b0, 3'd0, 3'd4, 1'b0)) begin
            n_fail++;
            $display("FAIL add_t4 got %h want %h", got, mk(3'd7, 5'b00100, 5'b0, 1'b0, 3'd0, 3'd4, 1'b0));
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        got = snap();
        if (got !== 21'h0) begin
            n_fail++;
            $display("FAIL async_reset got %h want %h", got, 21'h0);
        end
        bus.run = 1'b0;
        rst_n   = 1'b1;
    endtask

    task automatic test_lda();
        logic [20:0] want [7];
        logic [20:0] got;
        want[0] = mk(3'd2, 5'b10000, 5'b00000, 1'b0, 3'd0, 3'd0, 1'b0);
        want[1] = mk(3'd7, 5'b00001, 5'b01000, 1'b0, 3'd0, 3'd1, 1'b0);
        want[2] = mk(3'd5, 5'b10000, 5'b00000, 1'b0, 3'd0, 3'd2, 1'b0);
        want[3] = mk(3'd0, 5'b00000, 5'b00000, 1'b0, 3'd0, 3'd3, 1'b0);
        want[4] = mk(3'd7, 5'b00100, 5'b00000, 1'b0, 3'd0, 3'd4, 1'b0);
        want[5] = mk(3'd0, 5'b00010, 5'b00000, 1'b0, 3'd3, 3'd5, 1'b0);
        want[6] = mk(3'd2, 5'b10000, 5'b00000, 1'b0, 3'd0, 3'd0, 1'b0);
        go_t0(16'h2005);
        for (int i = 0; i < 7; i++) begin
            #1;
            n_tests++;
            got = snap();
            if (got !== want[i]) begin
                n_fail++;
                $display("FAIL lda_cyc%0d got %h want %h", i, got, want[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_add_indirect();
        logic [20:0] want [7];
        logic [20:0] got;
        want[0] = mk(3'd2, 5'b10000, 5'b00000, 1'b0, 3'd0, 3'd0, 1'b0);
        want[1] = mk(3'd7, 5'b00001, 5'b01000, 1'b0, 3'd0, 3'd1, 1'b0);
        want[2] = mk(3'd5, 5'b10000, 5'b00000, 1'b0, 3'd0, 3'd2, 1'b0);
        want[3] = mk(3'd7, 5'b10000, 5'b00000, 1'b0, 3'd0, 3'd3, 1'b0);
        want[4] = mk(3'd7, 5'b00100, 5'b00000, 1'b0, 3'd0, 3'd4, 1'b0);
        want[5] = mk(3'd0, 5'b00010, 5'b00000, 1'b0, 3'd2, 3'd5, 1'b0);
        want[6] = mk(3'd2, 5'b10000, 5'b00000, 1'b0, 3'd0, 3'd0, 1'b0);
        go_t0(16'h9010);
        for (int i = 0; i < 7; i++) begin
            #1;
            n_tests++;
            got = snap();
            if (got !== want[i]) begin
                n_fail++;
                $display("FAIL add_ind_cyc%0d got %h want %h", i, got, want[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_isz();
        logic [20:0] want [8];
        logic [20:0] got;
        for (int p = 0; p < 2; p++) begin
            want[0] = mk(3'd2, 5'b10000, 5'b00000, 1'b0, 3'd0, 3'd0, 1'b0);
            want[1] = mk(3'd7, 5'b00001, 5'b01000, 1'b0, 3'd0, 3'd1, 1'b0);
            want[2] = mk(3'd5, 5'b10000, 5'b00000, 1'b0, 3'd0, 3'd2, 1'b0);
            want[3] = mk(3'd0, 5'b00000, 5'b00000, 1'b0, 3'd0, 3'd3, 1'b0);
            want[4] = mk(3'd7, 5'b00100, 5'b00000, 1'b0, 3'd0, 3'd4, 1'b0);
            want[5] = mk(3'd0, 5'b00000, 5'b00100, 1'b0, 3'd0, 3'd5, 1'b0);
            want[6] = mk(3'd3, 5'b00000, (p == 0) ? 5'b01000 : 5'b00000, 1'b1, 3'd0, 3'd6, 1'b0);
            want[7] = mk(3'd2, 5'b10000, 5'b00000, 1'b0, 3'd0, 3'd0, 1'b0);
            bus.dr_zero = (p == 0);
            go_t0(16'h6020);
            for (int i = 0; i < 8; i++) begin
                #1;
                n_tests++;
                got = snap();
                if (got !== want[i]) begin
                    n_fail++;
                    $display("FAIL isz_dz%0d_cyc%0d got %h want %h", (p == 0), i, got, want[i]);
                end
                @(negedge clk);
            end
        end
        bus.dr_zero = 1'b0;
    endtask

    task automatic test_bsa();
        logic [20:0] want [3];
        logic [20:0] got;
        want[0] = mk(3'd2, 5'b00000, 5'b10000, 1'b1, 3'd0, 3'd4, 1'b0);
        want[1] = mk(3'd1, 5'b01000, 5'b00000, 1'b0, 3'd0, 3'd5, 1'b0);
        want[2] = mk(3'd2, 5'b10000, 5'b00000, 1'b0, 3'd0, 3'd0, 1'b0);
        go_t0(16'h5030);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            got = snap();
            if (got !== want[i]) begin
                n_fail++;
                $display("FAIL bsa_cyc%0d got %h want %h", i + 4, got, want[i]);
            end
            @(negedge clk);
        end
    endtask

    // STA with run dropped early (must finish, then idle), then BUN.
    task automatic test_sta_bun();
        logic [20:0] want [3];
        logic [20:0] got;
        want[0] = mk(3'd4, 5'b00000, 5'b00000, 1'b1, 3'd0, 3'd4, 1'b0);
        want[1] = 21'h0;
        want[2] = 21'h0;
        go_t0(16'h3040);
        bus.run = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            got = snap();
            if (got !== want[i]) begin
                n_fail++;
                $display("FAIL sta_cyc%0d got %h want %h", i + 4, got, want[i]);
            end
            @(negedge clk);
        end
        want[0] = mk(3'd1, 5'b01000, 5'b00000, 1'b0, 3'd0, 3'd4, 1'b0);
        want[1] = mk(3'd2, 5'b10000, 5'b00000, 1'b0, 3'd0, 3'd0, 1'b0);
        go_t0(16'h4050);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            #1;
            n_tests++;
            got = snap();
            if (got !== want[i]) begin
                n_fail++;
                $display("FAIL bun_cyc%0d got %h want %h", i + 4, got, want[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reg_ref();
        logic [15:0] irs  [5];
        logic        azs  [5];
        logic        ams  [5];
        logic [20:0] want [5];
        logic [20:0] got;
        logic [20:0] t0w;
        irs[0] = 16'h7804; azs[0] = 1'b1; ams[0] = 1'b0;
        want[0] = mk(3'd0, 5'b00000, 5'b01001, 1'b0, 3'd0, 3'd3, 1'b0);
        irs[1] = 16'h7A00; azs[1] = 1'b0; ams[1] = 1'b0;
        want[1] = mk(3'd0, 5'b00000, 5'b00001, 1'b0, 3'd0, 3'd3, 1'b0);
        irs[2] = 16'h7220; azs[2] = 1'b0; ams[2] = 1'b0;
        want[2] = mk(3'd0, 5'b00010, 5'b00010, 1'b0, 3'd4, 3'd3, 1'b0);
        irs[3] = 16'h7008; azs[3] = 1'b0; ams[3] = 1'b1;
        want[3] = mk(3'd0, 5'b00000, 5'b01000, 1'b0, 3'd0, 3'd3, 1'b0);
        irs[4] = 16'hF801; azs[4] = 1'b1; ams[4] = 1'b1;
        want[4] = mk(3'd0, 5'b00000, 5'b00000, 1'b0, 3'd0, 3'd3, 1'b0);
        t0w = mk(3'd2, 5'b10000, 5'b00000, 1'b0, 3'd0, 3'd0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            bus.ac_zero = azs[k];
            bus.ac_msb  = ams[k];
            go_t0(irs[k]);
            repeat (3) @(negedge clk);
            #1;
            n_tests++;
            got = snap();
            if (got !== want[k]) begin
                n_fail++;
                $display("FAIL rr_%h_t3 got %h want %h", irs[k], got, want[k]);
            end
            @(negedge clk);
            #1;
            n_tests++;
            got = snap();
            if (got !== t0w) begin
                n_fail++;
                $display("FAIL rr_%h_next got %h want %h", irs[k], got, t0w);
            end
        end
        bus.ac_zero = 1'b0;
        bus.ac_msb  = 1'b0;
    endtask

    task automatic test_halt();
        logic [20:0] got;
        logic [20:0] hw;
        hw = mk(3'd0, 5'b00000, 5'b00000, 1'b0, 3'd0, 3'd0, 1'b1);
        go_t0(16'h7001);
        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        got = snap();
        if (got !== mk(3'd0, 5'b0, 5'b0, 1'b0, 3'd0, 3'd3, 1'b0)) begin
            n_fail++;
            $display("FAIL hlt_t3 got %h want %h", got, mk(3'd0, 5'b0, 5'b0, 1'b0, 3'd0, 3'd3, 1'b0));
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            n_tests++;
            got = snap();
            if (got !== hw) begin
                n_fail++;
                $display("FAIL halted_cyc%0d got %h want %h", i, got, hw);
            end
            bus.run = ~bus.run;
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        got = snap();
        if (got !== 21'h0) begin
            n_fail++;
            $display("FAIL halt_reset got %h want %h", got, 21'h0);
        end
        bus.run = 1'b0;
        rst_n   = 1'b1;
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        bus.run     = 1'b0;
        bus.ir      = 16'h0000;
        bus.ac_zero = 1'b0;
        bus.ac_msb  = 1'b0;
        bus.dr_zero = 1'b0;
        test_reset();
        test_lda();
        test_add_indirect();
        test_isz();
        test_bsa();
        test_sta_bun();
        test_reg_ref();
        test_halt();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
